// File: rtl/int_stim_gen.sv
// rtl/int_stim_gen.sv - reset stretcher and scheduled interrupt stimulus generator
module int_stim_gen #(
    parameter int NCH        = 6,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 5,
    parameter int HOLD_MAX   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             pc_valid,
    input  logic [NCH-1:0]   irq_ack,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_val,
    output logic             cpu_reset,
    output logic [NCH-1:0]   hw_int,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [NCH-1:0]   overrun
);

    // Counter widths: the reset stretcher counts 0..RST_CYCLES-1, the hold
    // counter 0..HOLD_MAX-1 (kept at one bit when auto-clear is disabled).
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [1:0] MODE_OFF      = 2'd0;
    localparam logic [1:0] MODE_ONESHOT  = 2'd1;
    localparam logic [1:0] MODE_PERIODIC = 2'd2;
    localparam logic [1:0] MODE_PCMATCH  = 2'd3;

    typedef enum logic {
        G_HOLD,
        G_RUN
    } gstate_t;

    typedef enum logic [1:0] {
        CH_OFF,
        CH_ARMED,
        CH_ACTIVE
    } ch_state_t;

    gstate_t          gstate_q, gstate_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic             run;

    ch_state_t        ch_q    [NCH];
    ch_state_t        ch_d    [NCH];
    logic [1:0]       mode_q  [NCH];
    logic [1:0]       mode_d  [NCH];
    logic [CNT_W-1:0] val_q   [NCH];
    logic [CNT_W-1:0] val_d   [NCH];
    logic [CNT_W-1:0] nf_q    [NCH];
    logic [CNT_W-1:0] nf_d    [NCH];
    logic [HW-1:0]    hold_q  [NCH];
    logic [HW-1:0]    hold_d  [NCH];
    logic [NCH-1:0]   ovr_q, ovr_d;

    logic             cfg_legal;
    logic [NCH-1:0]   cfg_hit;
    logic [NCH-1:0]   trig;
    logic [NCH-1:0]   timeout;
    logic [NCH-1:0]   clr;

    assign run       = (gstate_q == G_RUN);
    assign cpu_reset = (gstate_q == G_HOLD);
    assign cycle_cnt = cycle_q;
    assign overrun   = ovr_q;
    assign cfg_legal = ({29'd0, cfg_ch} < 32'(NCH));

    // Global state register: reset stretcher and free-running cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            gstate_q  <= G_HOLD;
            rst_cnt_q <= '0;
            cycle_q   <= '0;
        end else begin
            gstate_q  <= gstate_d;
            rst_cnt_q <= rst_cnt_d;
            cycle_q   <= cycle_d;
        end
    end

    // Global next state: hold the CPU in reset for RST_CYCLES, then count cycles.
    always_comb begin
        gstate_d  = gstate_q;
        rst_cnt_d = rst_cnt_q;
        cycle_d   = cycle_q;
        case (gstate_q)
            G_HOLD: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    gstate_d  = G_RUN;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            G_RUN: begin
                cycle_d = cycle_q + CNT_W'(1);
            end
            default: begin
                gstate_d = G_HOLD;
            end
        endcase
    end

    // Per-channel trigger, timeout and clear conditions for the current cycle.
    always_comb begin
        cfg_hit = '0;
        trig    = '0;
        timeout = '0;
        clr     = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_hit[i] = cfg_we && cfg_legal && (cfg_ch == 3'(i));
            if (run && (ch_q[i] != CH_OFF)) begin
                case (mode_q[i])
                    MODE_ONESHOT:  trig[i] = (cycle_q == val_q[i]);
                    MODE_PERIODIC: trig[i] = (cycle_q == nf_q[i]);
                    MODE_PCMATCH:  trig[i] = pc_valid && (pc == 32'(val_q[i]));
                    default:       trig[i] = 1'b0;
                endcase
            end
            timeout[i] = (HOLD_MAX > 0) && (hold_q[i] == HW'(HOLD_MAX - 1));
            clr[i]     = (ch_q[i] == CH_ACTIVE) && (irq_ack[i] || timeout[i]);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ch_q[i]   <= CH_OFF;
                mode_q[i] <= MODE_OFF;
                val_q[i]  <= '0;
                nf_q[i]   <= '0;
                hold_q[i] <= '0;
            end
            ovr_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ch_q[i]   <= ch_d[i];
                mode_q[i] <= mode_d[i];
                val_q[i]  <= val_d[i];
                nf_q[i]   <= nf_d[i];
                hold_q[i] <= hold_d[i];
            end
            ovr_q <= ovr_d;
        end
    end

    // Channel next state: a config write wins over any trigger or clear that
    // cycle, so a freshly written schedule only compares from the next cycle.
    always_comb begin
        ovr_d = ovr_q;
        for (int i = 0; i < NCH; i++) begin
            ch_d[i]   = ch_q[i];
            mode_d[i] = mode_q[i];
            val_d[i]  = val_q[i];
            nf_d[i]   = nf_q[i];
            hold_d[i] = hold_q[i];
            if (cfg_hit[i]) begin
                mode_d[i] = cfg_mode;
                val_d[i]  = cfg_val;
                nf_d[i]   = cycle_q + cfg_val;
                hold_d[i] = '0;
                ovr_d[i]  = 1'b0;
                if ((cfg_mode == MODE_OFF) ||
                    ((cfg_mode == MODE_PERIODIC) && (cfg_val == '0))) begin
                    ch_d[i] = CH_OFF;
                end else begin
                    ch_d[i] = CH_ARMED;
                end
            end else begin
                // The periodic schedule advances on every hit, even while the
                // line is still high from the previous one.
                if ((mode_q[i] == MODE_PERIODIC) && trig[i]) begin
                    nf_d[i] = nf_q[i] + val_q[i];
                end
                case (ch_q[i])
                    CH_ARMED: begin
                        if (trig[i]) begin
                            ch_d[i]   = CH_ACTIVE;
                            hold_d[i] = '0;
                        end
                    end
                    CH_ACTIVE: begin
                        if (mode_q[i] == MODE_PERIODIC) begin
                            if (clr[i] && trig[i]) begin
                                // Cleared and re-fired at once: line stays up,
                                // fresh hold window, not an overrun.
                                hold_d[i] = '0;
                            end else if (clr[i]) begin
                                ch_d[i] = CH_ARMED;
                            end else begin
                                hold_d[i] = hold_q[i] + HW'(1);
                                if (trig[i]) begin
                                    ovr_d[i] = 1'b1;
                                end
                            end
                        end else if (clr[i]) begin
                            // One-shot and PC-match disarm after their single pulse.
                            ch_d[i] = CH_OFF;
                        end else begin
                            hold_d[i] = hold_q[i] + HW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Interrupt lines come straight from the channel state flops.
    always_comb begin
        hw_int = '0;
        for (int i = 0; i < NCH; i++) begin
            hw_int[i] = (ch_q[i] == CH_ACTIVE);
        end
    end

endmodule
